// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shifter family (left and right paths):
// default operand/shift-amount widths and the two-state FSM encoding.
package shift_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SHW   = 5;

    // FSM encoding kept as plain constants so older right-shift code can reuse it.
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

endpackage : shift_pkg

// File: rtl/left_shift_stage.sv
// One combinational stage of the barrel shifter: when enabled, shifts (zero fill)
// or rotates the input left by 2^index; otherwise passes it through unchanged.
module left_shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = DEFAULT_SHW
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   index,
    input  logic             enable,
    input  logic             rotate,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0]   shl;
    logic [2*WIDTH-1:0] doubled;

    // Logical shift: vacated LSBs are filled with zero.
    assign shl = data << (1 << index);

    // Rotate: shifting two concatenated copies brings the bits that leave the
    // MSB end back in at the LSB end of the upper half.
    assign doubled = {data, data} << (1 << index);

    // Per-bit output select between pass-through, shifted and rotated values.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign data_out[gi] = enable ? (rotate ? doubled[WIDTH+gi] : shl[gi])
                                         : data[gi];
        end
    endgenerate

endmodule : left_shift_stage

// File: rtl/seq_left_shifter.sv
// Sequential left shifter / rotator: one power-of-two stage per clock, largest
// stage first, fixed latency of SHW cycles regardless of the shift amount.
module seq_left_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = DEFAULT_SHW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] regi,
    input  logic [SHW-1:0]   shamt,
    input  logic             rotate,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    logic [0:0]       state_reg;
    logic [SHW-1:0]   cnt_reg;
    logic [SHW-1:0]   shamt_reg;
    logic             rotate_reg;
    logic [WIDTH-1:0] result_reg;
    logic             done_reg;

    logic [SHW-1:0]   stage_sel;
    logic             stage_enable;
    logic [WIDTH-1:0] stage_out;

    // The active stage is enabled when the latched shamt bit selected by the
    // counter is set; a one-hot compare avoids a variable-width bit select.
    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_sel
            assign stage_sel[gi] = (cnt_reg == SHW'(gi)) & shamt_reg[gi];
        end
    endgenerate
    assign stage_enable = |stage_sel;

    left_shift_stage #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_stage (
        .data     (result_reg),
        .index    (cnt_reg),
        .enable   (stage_enable & (state_reg == SHIFT)),
        .rotate   (rotate_reg),
        .data_out (stage_out)
    );

    // FSM, counter, latched controls, result and done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            shamt_reg  <= '0;
            rotate_reg <= 1'b0;
            result_reg <= '0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        result_reg <= regi;
                        shamt_reg  <= shamt;
                        rotate_reg <= rotate;
                        cnt_reg    <= SHW'(SHW - 1);
                        state_reg  <= SHIFT;
                    end
                end
                SHIFT: begin
                    result_reg <= stage_out;
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign result = result_reg;
    assign busy   = (state_reg == SHIFT);
    assign done   = done_reg;

endmodule : seq_left_shifter

// File: tb/tb_seq_left_shifter.sv
// Self-checking bench for seq_left_shifter: directed cases plus randomized
// operations compared against an arithmetic shift/rotate model.
module tb_seq_left_shifter;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] regi;
    logic [SHW-1:0]   shamt;
    logic             rotate;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    int checks;
    int errors;

    seq_left_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .regi   (regi),
        .shamt  (shamt),
        .rotate (rotate),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: x*2^s modulo 2^WIDTH, plus the wrapped-out high bits for rotate.
    function automatic logic [31:0] model(input logic [31:0] a, input int s, input bit r);
        logic [63:0] wide;
        wide = {32'd0, a} << s;
        if (r) return wide[31:0] | wide[63:32];
        return wide[31:0];
    endfunction

    // One operation; optional second start pulse (ignored by the DUT) before edge N+poke_k.
    task automatic run_op(input logic [31:0] a, input logic [4:0] s, input bit r,
                          input int poke_k, input string tag);
        logic [31:0] exp;
        int done_at;
        int done_cnt;
        int busy_cnt;
        logic [31:0] res_at_done;
        exp = model(a, int'(s), r);
        done_at = -1; done_cnt = 0; busy_cnt = 0; res_at_done = '0;
        @(negedge clk);
        regi = a; shamt = s; rotate = r; start = 1'b1;
        @(posedge clk); #1;                     // edge N
        start = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = k;
                    res_at_done = result;
                end
            end
            if (poke_k > 0 && k == poke_k - 1) begin
                start = 1'b1; regi = 32'hFFFF_FFFF; shamt = 5'd3; rotate = ~r;
            end else begin
                start = 1'b0;
            end
            if (k == 8) check({tag, "_hold"}, result, exp);
            if (k < 8) begin
                @(posedge clk); #1;
            end
        end
        check({tag, "_result"}, res_at_done, exp);
        check({tag, "_latency"}, 32'(done_at), 32'd5);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd5);
        $display("op %s regi=%h shamt=%0d rot=%0b result=%h exp=%h", tag, a, s, r, res_at_done, exp);
    endtask

    initial begin
        int d1;
        int d2;
        checks = 0; errors = 0;
        reset = 1'b1; start = 1'b0; regi = '0; shamt = '0; rotate = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", result, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Start accepted in the first cycle after reset release.
        run_op(32'h0000_00F1, 5'd4, 1'b0, 0, "lsl4");
        run_op(32'h8000_0001, 5'd31, 1'b1, 0, "rol31");
        run_op(32'h8000_0001, 5'd31, 1'b0, 0, "lsl31");
        run_op(32'hDEAD_BEEF, 5'd0, 1'b0, 0, "zero");
        run_op(32'hDEAD_BEEF, 5'd0, 1'b1, 0, "zero_rot");
        run_op(32'h0000_0001, 5'd16, 1'b0, 2, "busy_protect");
        check("busy_protect_abs", result, 32'h0001_0000);

        // Back-to-back: start held high through the done cycle.
        @(negedge clk);
        regi = 32'h1; shamt = 5'd1; rotate = 1'b0; start = 1'b1;
        @(posedge clk); #1;                     // edge N
        shamt = 5'd2;
        d1 = -1; d2 = -1;
        for (int k = 0; k <= 13; k++) begin
            if (done) begin
                if (d1 < 0) begin
                    d1 = k;
                    check("b2b_first", result, 32'h2);
                end else if (d2 < 0) begin
                    d2 = k;
                    check("b2b_second", result, 32'h4);
                end
            end
            if (k == 6) start = 1'b0;
            if (k < 13) begin
                @(posedge clk); #1;
            end
        end
        check("b2b_first_at", 32'(d1), 32'd5);
        check("b2b_gap", 32'(d2 - d1), 32'd6);
        $display("op b2b first_done=%0d second_done=%0d result=%h", d1, d2, result);

        // Reset mid-operation at edge N+3.
        @(negedge clk);
        regi = 32'h1234_5678; shamt = 5'd7; rotate = 1'b1; start = 1'b1;
        @(posedge clk); #1;                     // edge N
        start = 1'b0;
        d1 = 0;
        for (int k = 0; k < 2; k++) begin
            if (done) d1++;
            @(posedge clk); #1;
        end
        reset = 1'b1;                           // sampled at edge N+3
        @(posedge clk); #1;
        reset = 1'b0;
        if (done) d1++;
        check("rst_mid_result", result, 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_done", 32'(d1), 32'd0);
        $display("op reset_mid result=%h busy=%0b", result, busy);
        run_op(32'h0F0F_1234, 5'd9, 1'b1, 0, "after_reset");

        // Randomized operations.
        for (int i = 0; i < 30; i++) begin
            run_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_left_shifter
